// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between the MEM stage (master) and the data-memory
// responder (slave).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds valid and its payload steady until that edge.
// The sink may raise or lower ready at any time.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_write  master->slave  1 = store, 0 = load
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data, right-justified
//   req_size   master->slave  transfer size in bytes (1, 2, 4, 8)
//   rsp_valid  slave->master  response present
//   rsp_ready  master->slave  consumer accepts the response
//   rsp_rdata  slave->master  load data, zero-extended
//   rsp_err    slave->master  request was illegal, no side effects
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle, byte-addressed, little-endian data memory for the MEM stage.
// One request is serviced at a time. The access happens on the accept edge.
// The response is presented LATENCY cycles later and held until it is taken.
//
// Parameters:
//   DEPTH_WORDS  number of 64-bit storage words (byte capacity DEPTH_WORDS*8)
//   LATENCY      cycles from accept edge to rsp_valid being sampled high (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   dmem         slave side of dmem_responder_if (request + response channels)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = BUSY, 2 = RESP)
//
// Optional feature macro: DMEM_RSP_OVERLAP_EN
//   When defined, a new request can be accepted on the same edge that completes
//   the response handshake. The default build accepts requests only in IDLE.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave dmem,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [64:0] BYTE_CAP = 65'(DEPTH_WORDS) << 3;

    logic [63:0] r_mem [DEPTH_WORDS];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rsp_valid;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_size_ok;
    logic [7:0]  w_size_mask8;
    logic [63:0] w_size_mask64;
    logic        w_misaligned;
    logic [64:0] w_end;
    logic        w_oob;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [2:0]  w_off;
    logic [7:0]  w_lane_mask;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_word;
    logic [63:0] w_load;
    logic [63:0] w_rsp_data;
    logic        w_wr_en;
    state_t      w_launch_state;
    logic [3:0]  w_launch_cnt;

`ifdef DMEM_RSP_OVERLAP_EN
    assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && dmem.rsp_ready);
`else
    assign w_req_ready = (r_state == IDLE);
`endif

    assign w_accept = dmem.req_valid && w_req_ready;

    // Request decode and legality checks. These only matter on an accept edge.
    always_comb begin
        w_size_ok    = 1'b0;
        w_size_mask8 = 8'h00;
        case (dmem.req_size)
            4'd1: begin w_size_ok = 1'b1; w_size_mask8 = 8'h01; end
            4'd2: begin w_size_ok = 1'b1; w_size_mask8 = 8'h03; end
            4'd4: begin w_size_ok = 1'b1; w_size_mask8 = 8'h0F; end
            4'd8: begin w_size_ok = 1'b1; w_size_mask8 = 8'hFF; end
            default: begin w_size_ok = 1'b0; w_size_mask8 = 8'h00; end
        endcase

        w_size_mask64 = '0;
        for (int b = 0; b < 8; b++) begin
            w_size_mask64[b*8 +: 8] = {8{w_size_mask8[b]}};
        end

        // size-1 is a low-bit mask for the power-of-two sizes. Illegal sizes
        // are already rejected by w_size_ok.
        w_misaligned = |(dmem.req_addr[3:0] & (dmem.req_size - 4'd1));

        // A 65-bit sum so that addresses near 2^64 cannot wrap into range.
        w_end = {1'b0, dmem.req_addr} + {61'd0, dmem.req_size};
        w_oob = (w_end > BYTE_CAP);

        w_err = !w_size_ok || w_misaligned || w_oob;

        w_idx       = dmem.req_addr[3 +: AW];
        w_off       = dmem.req_addr[2:0];
        w_lane_mask = w_size_mask8 << w_off;
        w_wdata_sh  = dmem.req_wdata << {w_off, 3'b000};

        w_word = r_mem[w_idx];
        w_load = (w_word >> {w_off, 3'b000}) & w_size_mask64;

        w_rsp_data = (w_err || dmem.req_write) ? 64'd0 : w_load;
        w_wr_en    = w_accept && dmem.req_write && !w_err;

        w_launch_state = (LATENCY == 1) ? RESP : BUSY;
        w_launch_cnt   = (LATENCY == 1) ? 4'd0 : 4'(LATENCY - 1);
    end

    // Storage is deliberately not reset. A store committed before a reset survives it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (w_lane_mask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM. w_accept can only be true in IDLE, or in RESP while the
    // response is being taken (overlap build). Both cases launch the new request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_state     <= w_launch_state;
            r_cnt       <= w_launch_cnt;
            r_rsp_valid <= (LATENCY == 1);
            r_rsp_rdata <= w_rsp_data;
            r_rsp_err   <= w_err;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 4'd0;
                end
                BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_cnt       <= 4'd0;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (dmem.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= 4'd0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dmem.req_ready = w_req_ready;
    assign dmem.rsp_valid = r_rsp_valid;
    assign dmem.rsp_rdata = r_rsp_rdata;
    assign dmem.rsp_err   = r_rsp_err;
    assign o_dbg_state    = r_state;

endmodule
